// File: rtl/vga_timing_pkg.sv
// Shared types, timing table and helpers for the VGA timing engine.
// Each mode has one horizontal and one vertical axis descriptor. Field order on an axis:
// active, front porch, sync, back porch, plus the sync polarity (0 = active-low, 1 = active-high).
package vga_timing_pkg;

    localparam int VGA_NUM_MODE = 4;
    localparam int AXW          = 16;   // storage width of one table field

    typedef logic [AXW-1:0] axis_val_t;

    typedef struct packed {
        axis_val_t active;
        axis_val_t front;
        axis_val_t sync;
        axis_val_t back;
        logic      pol;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_mode_t;

    // Total length of one axis, in pixels (horizontal) or lines (vertical).
    function automatic axis_val_t axis_total(input vga_axis_t a);
        return a.active + a.front + a.sync + a.back;
    endfunction

    localparam vga_mode_t MODE_640X480 = '{
        h: '{active: 16'd640,  front: 16'd16, sync: 16'd96,  back: 16'd48,  pol: 1'b0},
        v: '{active: 16'd480,  front: 16'd10, sync: 16'd2,   back: 16'd33,  pol: 1'b0}};
    localparam vga_mode_t MODE_768X576 = '{
        h: '{active: 16'd768,  front: 16'd24, sync: 16'd80,  back: 16'd104, pol: 1'b0},
        v: '{active: 16'd576,  front: 16'd1,  sync: 16'd3,   back: 16'd17,  pol: 1'b1}};
    localparam vga_mode_t MODE_800X600 = '{
        h: '{active: 16'd800,  front: 16'd40, sync: 16'd128, back: 16'd88,  pol: 1'b1},
        v: '{active: 16'd600,  front: 16'd1,  sync: 16'd4,   back: 16'd23,  pol: 1'b1}};
    localparam vga_mode_t MODE_1024X768 = '{
        h: '{active: 16'd1024, front: 16'd24, sync: 16'd136, back: 16'd160, pol: 1'b0},
        v: '{active: 16'd768,  front: 16'd3,  sync: 16'd6,   back: 16'd29,  pol: 1'b0}};

    // Index 0 is the rightmost element of the concatenation.
    localparam vga_mode_t [VGA_NUM_MODE-1:0] VGA_MODES =
        {MODE_1024X768, MODE_800X600, MODE_768X576, MODE_640X480};

endpackage

// File: rtl/vga_timing_engine_if.sv
// Bundle between the timing engine and its consumer (glyph renderer / integrating top).
//   pix_ce, mode_req          : consumer -> engine (pixel enable, requested mode)
//   hsync, vsync, display_on,
//   hpos, vpos, line_start,
//   frame_start, frame_cnt,
//   mode_active, mode_ack     : engine -> consumer, all registered and mutually aligned
// master = engine side, slave = consumer side.
interface vga_timing_engine_if #(
    parameter int HW  = 11,
    parameter int VW  = 10,
    parameter int FCW = 8,
    parameter int MW  = 2
);
    logic           pix_ce;
    logic [MW-1:0]  mode_req;
    logic           hsync;
    logic           vsync;
    logic           display_on;
    logic [HW-1:0]  hpos;
    logic [VW-1:0]  vpos;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_cnt;
    logic [MW-1:0]  mode_active;
    logic           mode_ack;

    modport master (
        input  pix_ce, mode_req,
        output hsync, vsync, display_on, hpos, vpos, line_start, frame_start,
               frame_cnt, mode_active, mode_ack
    );

    modport slave (
        output pix_ce, mode_req,
        input  hsync, vsync, display_on, hpos, vpos, line_start, frame_start,
               frame_cnt, mode_active, mode_ack
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (used once for horizontal, once for vertical).
//   clk, rst_n : clock, asynchronous active-low reset
//   advance    : pixel clock enable
//   step       : count this enabled cycle (1 for H, H-wrap for V)
//   cfg        : axis descriptor of the active mode
//   cnt        : current position on the axis
//   wrap       : cnt is the last position of the axis
//   sync_level : sync output level for cnt, polarity already applied
//   in_active  : cnt lies in the active region
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    input  logic         step,
    input  vga_axis_t    cfg,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         sync_level,
    output logic         in_active
);

    logic [W-1:0] active_end;
    logic [W-1:0] sync_start;
    logic [W-1:0] sync_end;     // first position after the sync pulse
    logic [W-1:0] last_pos;
    logic         in_sync;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here unconditionally) so no latch is inferred.
        active_end = W'(cfg.active);
        sync_start = W'(cfg.active + cfg.front);
        sync_end   = W'(cfg.active + cfg.front + cfg.sync);
        last_pos   = W'(axis_total(cfg)) - W'(1);
        wrap       = (cnt == last_pos);
        in_active  = (cnt < active_end);
        in_sync    = (cnt >= sync_start) && (cnt < sync_end);
        sync_level = in_sync ? cfg.pol : ~cfg.pol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: position state is reset so the first frame after reset is a complete one.
            cnt <= '0;
        end else if (advance && step) begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_engine.sv
// VGA timing engine: table-driven sync generator with pixel clock-enable and frame-boundary
// mode switching.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : vga_timing_engine_if.master (pix_ce, mode_req in; sync/position/strobe/mode out)
// Two stages: the axis counters hold the current pixel; the output stage registers every
// output from that same pixel on pix_ce, so all outputs of a pixel appear together.
module vga_timing_engine
    import vga_timing_pkg::*;
#(
    parameter int HW           = 11,
    parameter int VW           = 10,
    parameter int FCW          = 8,
    parameter int NUM_MODE     = 4,
    parameter int DEFAULT_MODE = 3,
    parameter vga_mode_t [NUM_MODE-1:0] MODES = VGA_MODES
) (
    input logic                clk,
    input logic                rst_n,
    vga_timing_engine_if.master bus
);

    localparam int              MW         = (NUM_MODE > 1) ? $clog2(NUM_MODE) : 1;
    localparam logic [MW-1:0]   RST_MODE   = MW'(DEFAULT_MODE);
    localparam logic            RST_HSYNC  = ~MODES[DEFAULT_MODE].h.pol;
    localparam logic            RST_VSYNC  = ~MODES[DEFAULT_MODE].v.pol;

    // ---------------- mode control ----------------
    logic [MW-1:0]  mode_active;
    logic [MW-1:0]  pending;
    logic           pending_vld;
    logic           mode_ack;
    vga_mode_t      cur;
    logic           req_ok;
    logic           frame_wrap;

    // ---------------- counter stage ----------------
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic           h_last, v_last;
    logic           h_sync_lvl, v_sync_lvl;
    logic           h_act, v_act;
    logic [FCW-1:0] frames_done;

    // ---------------- output stage ----------------
    logic           hsync_q, vsync_q, display_on_q;
    logic [HW-1:0]  hpos_q;
    logic [VW-1:0]  vpos_q;
    logic           line_start_q, frame_start_q;
    logic [FCW-1:0] frame_cnt_q;

    always_comb begin
        cur        = MODES[mode_active];
        req_ok     = (32'(bus.mode_req) < 32'(NUM_MODE));
        frame_wrap = bus.pix_ce && h_last && v_last;
    end

    vga_axis_counter #(.W(HW)) u_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (bus.pix_ce),
        .step       (1'b1),
        .cfg        (cur.h),
        .cnt        (h_cnt),
        .wrap       (h_last),
        .sync_level (h_sync_lvl),
        .in_active  (h_act)
    );

    vga_axis_counter #(.W(VW)) u_v (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (bus.pix_ce),
        .step       (h_last),
        .cfg        (cur.v),
        .cnt        (v_cnt),
        .wrap       (v_last),
        .sync_level (v_sync_lvl),
        .in_active  (v_act)
    );

    // The frame-wrap edge already returns both counters to 0, so switching mode_active on that
    // same edge makes pixel (0,0) of the next frame the first one decoded with the new table.
    // A request sampled on the applying edge itself is dropped; mode_req is level-sampled, so a
    // held request is picked up again one clk later against the new mode_active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_active <= RST_MODE;
            pending     <= RST_MODE;
            pending_vld <= 1'b0;
            mode_ack    <= 1'b0;
        end else begin
            mode_ack <= 1'b0;
            if (frame_wrap && pending_vld) begin
                mode_active <= pending;
                pending_vld <= 1'b0;
                mode_ack    <= 1'b1;
            end else if (req_ok) begin
                if (bus.mode_req != mode_active) begin
                    pending     <= bus.mode_req;
                    pending_vld <= 1'b1;
                end else begin
                    pending_vld <= 1'b0;    // asking for the running mode cancels
                end
            end
        end
    end

    // Counts wraps at the counter stage; the output stage copies it with pixel (0,0) so the
    // new count appears together with frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_done <= '0;
        end else if (frame_wrap) begin
            frames_done <= frames_done + FCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= RST_HSYNC;
            vsync_q       <= RST_VSYNC;
            display_on_q  <= 1'b0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else if (bus.pix_ce) begin
            hsync_q       <= h_sync_lvl;
            vsync_q       <= v_sync_lvl;
            display_on_q  <= h_act && v_act;
            hpos_q        <= h_cnt;
            vpos_q        <= v_cnt;
            line_start_q  <= (h_cnt == '0);
            frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
            frame_cnt_q   <= frames_done;
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.display_on  = display_on_q;
    assign bus.hpos        = hpos_q;
    assign bus.vpos        = vpos_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.mode_active = mode_active;
    assign bus.mode_ack    = mode_ack;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Testbench for vga_timing_engine.
// dut_full runs the built-in table in 1024x768 with pix_ce=1 and is checked for its first lines.
// dut runs a reduced three-mode table (short enough for many frames) under randomized pix_ce and
// mode requests; a reference model pushes expected pixels into a scoreboard that a monitor drains.
module tb_vga_timing_engine;
    import vga_timing_pkg::*;

    localparam int HW = 11, VW = 10, FCW = 8;
    localparam int NM = 3, MW = 2, DM = 2;

    // Reduced timing table, one entry per mode.
    localparam int HA[NM] = '{8, 6, 10};
    localparam int HF[NM] = '{2, 1, 1};
    localparam int HS[NM] = '{3, 2, 2};
    localparam int HB[NM] = '{2, 3, 1};
    localparam int HP[NM] = '{0, 0, 1};
    localparam int VA[NM] = '{4, 3, 5};
    localparam int VF[NM] = '{1, 1, 1};
    localparam int VS[NM] = '{2, 1, 1};
    localparam int VB[NM] = '{1, 2, 1};
    localparam int VP[NM] = '{0, 1, 1};

    function automatic vga_mode_t mk(input int m);
        vga_mode_t r;
        r.h.active = 16'(HA[m]); r.h.front = 16'(HF[m]); r.h.sync = 16'(HS[m]);
        r.h.back   = 16'(HB[m]); r.h.pol   = (HP[m] != 0);
        r.v.active = 16'(VA[m]); r.v.front = 16'(VF[m]); r.v.sync = 16'(VS[m]);
        r.v.back   = 16'(VB[m]); r.v.pol   = (VP[m] != 0);
        return r;
    endfunction

    localparam vga_mode_t [NM-1:0] SMALL = {mk(2), mk(1), mk(0)};

    typedef struct {
        int hpos, vpos, fc;
        bit hs, vs, de, ls, fs;
    } pix_t;

    typedef struct {
        int mode;
        bit ack;
    } mode_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_timing_engine_if #(.HW(HW), .VW(VW), .FCW(FCW), .MW(MW)) s_if ();
    vga_timing_engine_if #(.HW(11), .VW(10), .FCW(8), .MW(2))    f_if ();

    vga_timing_engine #(.HW(HW), .VW(VW), .FCW(FCW), .NUM_MODE(NM), .DEFAULT_MODE(DM),
                        .MODES(SMALL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    vga_timing_engine dut_full (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (f_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got nothing expected an entry at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    pix_t      pq[$];
    mode_exp_t mq[$];
    pix_t      last_exp;
    int        m_mode, m_idx, m_fc, m_pend;
    bit        m_pvld;
    bit        full_done = 1'b0;

    function automatic int frame_len(input int m);
        return (HA[m] + HF[m] + HS[m] + HB[m]) * (VA[m] + VF[m] + VS[m] + VB[m]);
    endfunction

    // Output expected for pixel number idx (raster order from the top-left) of mode m.
    function automatic pix_t expect_pix(input int m, input int idx, input int fc);
        pix_t e;
        int   ht, h, v;
        ht     = HA[m] + HF[m] + HS[m] + HB[m];
        h      = idx % ht;
        v      = idx / ht;
        e.hpos = h;
        e.vpos = v;
        e.hs   = ((h >= HA[m] + HF[m]) && (h < HA[m] + HF[m] + HS[m])) ? (HP[m] != 0) : (HP[m] == 0);
        e.vs   = ((v >= VA[m] + VF[m]) && (v < VA[m] + VF[m] + VS[m])) ? (VP[m] != 0) : (VP[m] == 0);
        e.de   = (h < HA[m]) && (v < VA[m]);
        e.ls   = (h == 0);
        e.fs   = (idx == 0);
        e.fc   = fc % 256;
        return e;
    endfunction

    function automatic pix_t reset_pix();
        pix_t e;
        e.hpos = 0; e.vpos = 0; e.fc = 0;
        e.hs = (HP[DM] == 0); e.vs = (VP[DM] == 0);
        e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        m_mode = DM; m_idx = 0; m_fc = 0; m_pend = DM; m_pvld = 1'b0;
        pq.delete();
        mq.delete();
        last_exp = reset_pix();
    endtask

    always @(posedge clk) begin
        if (rst_n) begin : model_step
            bit applied;
            int req;
            applied = 1'b0;
            req     = int'(s_if.mode_req);
            if (s_if.pix_ce) begin
                pq.push_back(expect_pix(m_mode, m_idx, m_fc));
                if (m_idx == frame_len(m_mode) - 1) begin
                    m_idx = 0;
                    m_fc++;
                    if (m_pvld) begin
                        m_mode  = m_pend;
                        m_pvld  = 1'b0;
                        applied = 1'b1;
                    end
                end else begin
                    m_idx++;
                end
            end
            if (!applied && req < NM) begin
                if (req != m_mode) begin
                    m_pend = req;
                    m_pvld = 1'b1;
                end else begin
                    m_pvld = 1'b0;
                end
            end
            mq.push_back('{mode: m_mode, ack: applied});
        end
    end

    task automatic compare_pix(input string tag, input pix_t e);
        check({tag, "_hpos"},        s_if.hpos,        e.hpos);
        check({tag, "_vpos"},        s_if.vpos,        e.vpos);
        check({tag, "_hsync"},       s_if.hsync,       e.hs);
        check({tag, "_vsync"},       s_if.vsync,       e.vs);
        check({tag, "_display_on"},  s_if.display_on,  e.de);
        check({tag, "_line_start"},  s_if.line_start,  e.ls);
        check({tag, "_frame_start"}, s_if.frame_start, e.fs);
        check({tag, "_frame_cnt"},   s_if.frame_cnt,   e.fc);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin : monitor
        bit        pce, rst_seen;
        pix_t      e;
        mode_exp_t me;
        pce      = s_if.pix_ce;
        rst_seen = rst_n;
        #1;
        if (rst_seen && rst_n) begin
            if (mq.size() == 0) begin
                fail_now("mode_queue_empty");
            end else begin
                me = mq.pop_front();
                check("mode_active", s_if.mode_active, me.mode);
                check("mode_ack",    s_if.mode_ack,    me.ack);
            end
            if (pce) begin
                if (pq.size() == 0) begin
                    fail_now("pixel_queue_empty");
                end else begin
                    e = pq.pop_front();
                    compare_pix("pix", e);
                    last_exp = e;
                end
            end else begin
                compare_pix("hold", last_exp);
            end
        end
    end

    // ---------------- full-table checker (1024x768, pix_ce always 1) ----------------
    initial begin : full_chk
        int p, eh, ev;
        @(posedge rst_n);
        for (int k = 1; k <= 3 * 1344 + 20; k++) begin
            @(posedge clk);
            #1;
            p  = k - 1;
            eh = p % 1344;
            ev = p / 1344;
            check("full_hpos",       f_if.hpos,       eh);
            check("full_vpos",       f_if.vpos,       ev);
            check("full_hsync",      f_if.hsync,      !((eh >= 1048) && (eh <= 1183)));
            check("full_vsync",      f_if.vsync,      !((ev >= 771) && (ev <= 776)));
            check("full_display_on", f_if.display_on, (eh < 1024) && (ev < 768));
            check("full_line_start", f_if.line_start, eh == 0);
            check("full_mode",       f_if.mode_active, 3);
        end
        full_done = 1'b1;
    end

    // ---------------- stimulus ----------------
    // pce_kind: 0 = always on, 1 = one-in-two, 2 = random ~75%
    task automatic drive(input int n, input int pce_kind, input int req);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (pce_kind)
                0:       s_if.pix_ce = 1'b1;
                1:       s_if.pix_ce = ~s_if.pix_ce;
                default: s_if.pix_ce = ($urandom_range(0, 3) != 0);
            endcase
            s_if.mode_req = MW'(req);
        end
    endtask

    task automatic check_small_reset(input string tag);
        pix_t r;
        r = reset_pix();
        compare_pix(tag, r);
        check({tag, "_mode_active"}, s_if.mode_active, DM);
        check({tag, "_mode_ack"},    s_if.mode_ack,    0);
    endtask

    initial begin : driver
        int req, budget;
        rst_n         = 1'b0;
        s_if.pix_ce   = 1'b1;
        s_if.mode_req = MW'(DM);
        f_if.pix_ce   = 1'b1;
        f_if.mode_req = 2'd3;
        model_reset();
        repeat (3) @(negedge clk);
        check_small_reset("rst");
        check("rst_full_hsync", f_if.hsync, 1);
        check("rst_full_vsync", f_if.vsync, 1);
        check("rst_full_mode",  f_if.mode_active, 3);
        rst_n = 1'b1;

        drive(150, 0, DM);                  // default mode, continuous pixels
        drive(300, 0, 0);                   // request mode 0 mid-frame
        s_if.pix_ce = 1'b0;
        drive(400, 1, 0);                   // one-in-two pixel enable
        drive(3, 0, 2);                     // 0 -> 2 -> 0 inside one frame
        drive(40, 0, 0);
        drive(5, 0, 3);                     // out-of-range request
        drive(60, 0, 0);

        req = 1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 59) == 0) req = $urandom_range(0, 3);
            drive(1, 2, req);
        end

        budget = 0;
        while (!full_done && budget < 5000) begin
            drive(1, 2, req);
            budget++;
        end
        check("full_checker_done", full_done, 1);

        // Move to mode 2 and drop reset in the middle of a frame.
        budget = 0;
        while (!(m_mode == 2 && m_idx > 20 && m_idx < 90) && budget < 2000) begin
            drive(1, 0, 2);
            budget++;
        end
        check("reach_mode2_midframe", m_mode, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_small_reset("async_rst");
        check("async_rst_full_hsync", f_if.hsync, 1);
        check("async_rst_full_hpos",  f_if.hpos,  0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(400, 2, DM);

        drive(3, 0, DM);
        @(negedge clk);
        s_if.pix_ce = 1'b0;
        repeat (2) @(negedge clk);
        check("pixel_queue_drained", pq.size(), 0);
        check("mode_queue_drained",  mq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
